// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared types and constants for the Sobel window generator.
//   win_state_e : frame-level FSM states (IDLE, RUN, DRAIN, DONE)
//   WIN_TAPS    : number of pixels in a 3x3 window
//   pixel_t     : pixel word at the default pixel width
// -----------------------------------------------------------------------------
package sobel_pkg;

    localparam int WIN_TAPS      = 9;
    localparam int PIX_W_DEFAULT = 32;

    typedef logic [PIX_W_DEFAULT-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } win_state_e;

endpackage

// File: rtl/sobel_line_buffer.sv
// -----------------------------------------------------------------------------
// sobel_line_buffer
// Single-port, DEPTH-deep register array holding one image row.
// Read is combinational and returns the old contents when a write targets the
// same index in the same cycle (read-before-write).
// Ports:
//   clk     : rising-edge clock
//   addr    : shared read/write index
//   wr_en   : write strobe
//   wr_data : data written at addr on the clock edge
//   rd_data : current contents at addr
// -----------------------------------------------------------------------------
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int W     = PIX_W_DEFAULT
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // NOTE: storage arrays are deliberately not reset; the window generator
    // masks every location until it has been written in the current frame.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// -----------------------------------------------------------------------------
// sobel_window_gen
// Streaming 3x3 neighbourhood generator feeding the Sobel filter. Accepts one
// raster-order HEIGHT x WIDTH frame and emits one border-padded window per
// pixel, in raster order of window centre, using two line buffers and a
// 3x3 shift window. The scan walks a (HEIGHT+1) x (WIDTH+1) grid; the extra
// row/column are pad steps that flush the bottom/right borders.
//
// Optional build macro SOBEL_WINDOW_REPLICATE_PAD_EN: border pixels are
// replicated from the nearest edge instead of being zero-filled.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begins a frame (ignored unless idle)
//   in_valid/in_ready/in_pixel : input pixel stream
//   out_valid/out_ready        : output window handshake
//   out_window  : 9 pixels, element k=m*3+n at [k*PIX_W +: PIX_W]
//   out_row/out_col : window centre coordinates
//   out_last    : window for the bottom-right centre
//   busy        : frame in progress (RUN or DRAIN)
//   frame_done  : one-cycle pulse after the last window handshake
// -----------------------------------------------------------------------------
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int HEIGHT = 5,
    parameter int PIX_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [PIX_W-1:0]            in_pixel,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [WIN_TAPS*PIX_W-1:0]   out_window,
    output logic [$clog2(HEIGHT)-1:0]   out_row,
    output logic [$clog2(WIDTH)-1:0]    out_col,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam int AW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    localparam logic [XW-1:0] X_PAD = XW'(WIDTH);
    localparam logic [YW-1:0] Y_PAD = YW'(HEIGHT);
    localparam logic [XW-1:0] X_ONE = XW'(1);
    localparam logic [YW-1:0] Y_ONE = YW'(1);

    win_state_e state, state_next;

    logic [YW-1:0] y;
    logic [XW-1:0] x;
    logic [YW-1:0] y_m1;
    logic [XW-1:0] x_m1;

    logic in_pos, emits, step_ok, step, last_step;

    logic [AW-1:0]    lb_addr;
    logic             lb_wr;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic [PIX_W-1:0] cur, row_m1, row_m2;

    // Column layout [row]: 0 = row y-2, 1 = row y-1, 2 = current row.
    // Window layout [col]: 0 = column x-2, 1 = column x-1, 2 = column x.
    logic [2:0][PIX_W-1:0]       col_new;
    logic [1:0][2:0][PIX_W-1:0]  hist_q;
    logic [2:0][2:0][PIX_W-1:0]  win_d;
    logic [WIN_TAPS*PIX_W-1:0]   win_flat;

    // ---------------------------------------------------------------- control
    assign in_pos    = (y != Y_PAD) && (x != X_PAD);
    assign emits     = (y != '0) && (x != '0);
    assign last_step = (y == Y_PAD) && (x == X_PAD);
    // A step that registers a window needs the output register free.
    assign step_ok   = !emits || !out_valid || out_ready;
    assign step      = (state == RUN) && step_ok && (!in_pos || in_valid);
    assign in_ready  = (state == RUN) && in_pos && step_ok;

    assign busy       = (state == RUN) || (state == DRAIN);
    assign frame_done = (state == DONE);

    assign y_m1 = y - Y_ONE;
    assign x_m1 = x - X_ONE;

    // NOTE: state and all other registers use non-blocking assignments so every
    // flop samples its inputs from the same clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default assignment first keeps this block purely combinational.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (step && last_step) state_next = DRAIN;
            DRAIN:   if (out_valid && out_ready && out_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------ line buffers
    // The pad column has no storage; park the address at 0 and never write it.
    assign lb_addr = (x == X_PAD) ? '0 : x[AW-1:0];
    assign lb_wr   = step && (x != X_PAD);

    sobel_line_buffer #(.DEPTH(WIDTH), .W(PIX_W)) lb0 (
        .clk     (clk),
        .addr    (lb_addr),
        .wr_en   (lb_wr),
        .wr_data (cur),
        .rd_data (lb0_rd)
    );

    sobel_line_buffer #(.DEPTH(WIDTH), .W(PIX_W)) lb1 (
        .clk     (clk),
        .addr    (lb_addr),
        .wr_en   (lb_wr),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // --------------------------------------------------------- new column mux
    always_comb begin
        row_m1 = (y != '0 && x != X_PAD) ? lb0_rd : '0;
`ifdef SOBEL_WINDOW_REPLICATE_PAD_EN
        // Top border repeats row 0, bottom border repeats row HEIGHT-1,
        // right border repeats the previous column.
        row_m2  = (y > Y_ONE) ? lb1_rd : row_m1;
        cur     = (y == Y_PAD) ? row_m1 : in_pixel;
        col_new = (x == X_PAD) ? hist_q[1] : {cur, row_m1, row_m2};
`else
        row_m2  = (y > Y_ONE && x != X_PAD) ? lb1_rd : '0;
        cur     = in_pos ? in_pixel : '0;
        col_new = {cur, row_m1, row_m2};
`endif
    end

    // ------------------------------------------------------ shift window next
    always_comb begin
        win_d = '0;
        if (x == '0) begin
            // Start of a scan row: the older columns lie left of the frame.
`ifdef SOBEL_WINDOW_REPLICATE_PAD_EN
            win_d = {col_new, col_new, col_new};
`else
            win_d[2] = col_new;
`endif
        end else begin
            win_d = {col_new, hist_q[1], hist_q[0]};
        end
    end

    always_comb begin
        win_flat = '0;
        for (int m = 0; m < 3; m++) begin
            for (int n = 0; n < 3; n++) begin
                win_flat[(m*3+n)*PIX_W +: PIX_W] = win_d[n][m];
            end
        end
    end

    // ------------------------------------------------- scan counters, outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y          <= '0;
            x          <= '0;
            hist_q     <= '0;
            out_valid  <= 1'b0;
            out_window <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_last   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                y <= '0;
                x <= '0;
            end else if (step) begin
                hist_q <= {win_d[2], win_d[1]};
                if (x == X_PAD) begin
                    x <= '0;
                    y <= (y == Y_PAD) ? '0 : y + Y_ONE;
                end else begin
                    x <= x + X_ONE;
                end
            end

            if (step && emits) begin
                out_valid  <= 1'b1;
                out_window <= win_flat;
                out_row    <= y_m1[RW-1:0];
                out_col    <= x_m1[AW-1:0];
                out_last   <= last_step;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
`timescale 1ns/1ps
module tb_sobel_window_gen;
    import sobel_pkg::*;

    localparam int W    = 5;
    localparam int H    = 5;
    localparam int PW   = 32;
    localparam int WINW = WIN_TAPS * PW;

    typedef struct packed {
        logic [WINW-1:0] win;
        logic [2:0]      row;
        logic [2:0]      col;
        logic            last;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            in_valid;
    logic [PW-1:0]   in_pixel;
    logic            in_ready;
    logic            out_valid;
    logic [WINW-1:0] out_window;
    logic [2:0]      out_row;
    logic [2:0]      out_col;
    logic            out_last;
    logic            out_ready;
    logic            busy;
    logic            frame_done;

    sobel_window_gen #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_window (out_window),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t exp_item;
    int   cyc = 0;
    int   cur_base = 0;
    bit   rnd_ready = 0;
    int   n_win = 0;
    int   last_hs_cyc = 0;
    int   first_valid_cyc = -1;
    int   acc_cyc[W*H];
    bit   hold_pending = 0;
    logic [WINW+6:0] held;

    // Hand-computed windows for the frame pixel(r,c) = r*5+c+1.
`ifdef SOBEL_WINDOW_REPLICATE_PAD_EN
    int hand00[9] = '{1, 1, 2, 1, 1, 2, 6, 6, 7};
    int hand44[9] = '{19, 20, 20, 24, 25, 25, 24, 25, 25};
`else
    int hand00[9] = '{0, 0, 0, 0, 1, 2, 0, 6, 7};
    int hand44[9] = '{19, 20, 0, 24, 25, 0, 0, 0, 0};
`endif
    int hand22[9] = '{7, 8, 9, 12, 13, 14, 17, 18, 19};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [WINW+7:0] act,
                         input logic [WINW+7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference: padded-frame lookup.
    function automatic int pv(input int base, input int r, input int c);
`ifdef SOBEL_WINDOW_REPLICATE_PAD_EN
        if (r < 0) r = 0;
        if (r > H-1) r = H-1;
        if (c < 0) c = 0;
        if (c > W-1) c = W-1;
`else
        if (r < 0 || r >= H || c < 0 || c >= W) return 0;
`endif
        return base + r*W + c + 1;
    endfunction

    function automatic logic [WINW-1:0] model_win(input int base, input int r, input int c);
        logic [WINW-1:0] w;
        w = '0;
        for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++)
                w[(m*3+n)*PW +: PW] = PW'(pv(base, r+m-1, c+n-1));
        return w;
    endfunction

    function automatic logic [WINW-1:0] pack9(input int v[9]);
        logic [WINW-1:0] w;
        for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(v[k]);
        return w;
    endfunction

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Monitor: pops and compares on each handshake, checks hold stability.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            hold_pending = 0;
        end else begin
            if (hold_pending)
                check("hold_stable", {out_valid, out_window, out_row, out_col, out_last},
                      {1'b1, held});
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                n_win++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_window: got row %0d col %0d, required none",
                             out_row, out_col);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("window", {out_window, out_row, out_col, out_last}, exp_item);
                end
                if (cur_base == 0 && out_row == 0 && out_col == 0)
                    check("hand_r0c0", out_window, pack9(hand00));
                if (cur_base == 0 && out_row == 2 && out_col == 2)
                    check("hand_r2c2", out_window, pack9(hand22));
                if (cur_base == 0 && out_row == 4 && out_col == 4)
                    check("hand_r4c4", {out_window, out_last}, {pack9(hand44), 1'b1});
                if (out_last) last_hs_cyc = cyc;
            end
            hold_pending = out_valid && !out_ready;
            held = {out_window, out_row, out_col, out_last};
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic begin_frame(input int base);
        n_win = 0;
        cur_base = base;
        first_valid_cyc = -1;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_q.push_back({model_win(base, r, c), 3'(r), 3'(c),
                                 (r == H-1 && c == W-1)});
        pulse_start();
    endtask

    task automatic drive_pixels(input int base, input bit rnd, input int n_pix);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < n_pix && guard < 3000) begin
            in_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_pixel = PW'(base + idx + 1);
            @(negedge clk);
            if (in_valid && in_ready) begin
                acc_cyc[idx] = cyc + 1;
                idx++;
            end
            @(posedge clk);
            #2;
            guard++;
        end
        in_valid = 1'b0;
        if (idx < n_pix) begin
            n_cmp++;
            n_fail++;
            $display("FAIL pixel_accept_timeout: got %0d pixels, required %0d", idx, n_pix);
        end
    endtask

    task automatic finish_frame();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!frame_done && guard < 3000);
        if (!frame_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_done_timeout: got 0, required 1");
        end else begin
            check("done_timing", cyc, last_hs_cyc + 1);
            @(negedge clk);
            check("done_pulse_width", frame_done, 0);
        end
        check("window_count", n_win, W*H);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_outputs",
              {out_valid, out_last, out_row, out_col, busy, frame_done, in_ready, out_window}, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("idle_not_busy", busy, 0);

        // Frame A: always ready, latency and throughput.
        begin_frame(0);
        check("busy_in_run", busy, 1);
        drive_pixels(0, 0, W*H);
        finish_frame();
        check("first_window_latency", first_valid_cyc, acc_cyc[6]);
        for (int i = 1; i < W*H; i++)
            check("accept_gap", acc_cyc[i] - acc_cyc[i-1], (i % W == 0) ? 2 : 1);

        // Frame B: random in_valid/out_ready, stray start during RUN.
        @(posedge clk);
        #2;
        rnd_ready = 1;
        begin_frame(0);
        fork
            drive_pixels(0, 1, W*H);
            begin
                repeat (10) @(posedge clk);
                #3;
                start = 1'b1;
                @(posedge clk);
                #3;
                start = 1'b0;
            end
        join
        finish_frame();
        rnd_ready = 0;

        // Frame C: reset after 12 pixels.
        @(posedge clk);
        #2;
        begin_frame(50);
        drive_pixels(50, 0, 12);
        rst_n = 1'b0;
        #1;
        check("reset_mid_frame",
              {out_valid, out_last, out_row, out_col, busy, frame_done, in_ready, out_window}, '0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Frame D: full frame after the aborted one, no stale data.
        begin_frame(100);
        drive_pixels(100, 0, W*H);
        finish_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
